// File: rtl/barcode_pkg.sv
// Shared types and constants for the floor-barcode receiver.
package barcode_pkg;

   localparam int unsigned FRAME_BITS = 8;
   localparam logic [1:0]  ID_PREFIX  = 2'b00;
   localparam int unsigned STALL_MULT = 4;

   typedef enum logic [2:0] {
      IDLE,
      MEAS,
      WAIT_FALL,
      SAMPLE_WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/bc_sync_edge.sv
// BC synchronizer and edge detector; BC_GLITCH_FILTER_EN adds a 3-tap majority filter
// ahead of the edge detector.
module bc_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic bc,
   output logic line,
   output logic fall,
   output logic rise
);

   logic s1, s2, prev;

`ifdef BC_GLITCH_FILTER_EN
   logic d1, d2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d1 <= 1'b1;
         d2 <= 1'b1;
      end else begin
         d1 <= s2;
         d2 <= d1;
      end
   end

   // Majority over the last three synchronized samples rejects single-cycle pulses.
   always_comb line = (s2 & d1) | (s2 & d2) | (d1 & d2);
`else
   always_comb line = s2;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b1;
      end else begin
         s1   <= bc;
         s2   <= s1;
         prev <= line;
      end
   end

   always_comb begin
      fall = prev & ~line;
      rise = ~prev & line;
   end

endmodule

// File: rtl/barcode_rx.sv
// Self-timed floor-barcode decoder: the start-bit low time sets the data sample delay.
// Optional glitch filter is enabled with BC_GLITCH_FILTER_EN (see bc_sync_edge).
module barcode_rx #(
   parameter int unsigned CNT_W      = 22,
   parameter int unsigned FRAME_BITS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       BC,
   input  logic       clr_ID_vld,
   output logic [7:0] ID,
   output logic       ID_vld
);
   import barcode_pkg::*;

   localparam int unsigned SW = CNT_W + 2;

   logic line, fall, rise;

   bc_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .bc    (BC),
      .line  (line),
      .fall  (fall),
      .rise  (rise)
   );

   state_t           state, state_next;
   logic [CNT_W-1:0] period_cnt, samp_cnt, t_half;
   logic [SW-1:0]    stall_cnt;
   logic [3:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             sample_now, last_bit, id_ok;
   logic             period_sat, samp_sat, stall_exp;

   always_comb begin
      period_sat = &period_cnt;
      samp_sat   = &samp_cnt;
      stall_exp  = stall_cnt > (SW'(t_half) * SW'(STALL_MULT));
      sample_now = (state == SAMPLE_WAIT) && (samp_cnt == t_half);
      last_bit   = (bit_cnt + 4'd1) == 4'(FRAME_BITS);
      id_ok      = shreg[7:6] == ID_PREFIX;
      state_next = state;
      case (state)
         IDLE:        if (fall) state_next = MEAS;
         MEAS: begin
            if (rise)            state_next = WAIT_FALL;
            else if (period_sat) state_next = IDLE;
         end
         WAIT_FALL: begin
            if (fall)           state_next = SAMPLE_WAIT;
            else if (stall_exp) state_next = IDLE;
         end
         // Falling edges before the sample point are ignored as noise.
         SAMPLE_WAIT: begin
            if (sample_now)    state_next = last_bit ? DONE : WAIT_FALL;
            else if (samp_sat) state_next = IDLE;
         end
         DONE:        state_next = IDLE;
         default:     state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         period_cnt <= '0;
         samp_cnt   <= '0;
         t_half     <= '0;
         stall_cnt  <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         ID         <= '0;
         ID_vld     <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (fall) period_cnt <= '0;
            MEAS: begin
               if (rise) begin
                  t_half    <= (period_cnt == '0) ? CNT_W'(1) : period_cnt;
                  bit_cnt   <= '0;
                  stall_cnt <= '0;
               end else if (!line && !period_sat) begin
                  period_cnt <= period_cnt + 1'b1;
               end
            end
            WAIT_FALL: begin
               if (fall) samp_cnt  <= '0;
               else      stall_cnt <= stall_cnt + 1'b1;
            end
            SAMPLE_WAIT: begin
               if (sample_now) begin
                  shreg     <= {shreg[6:0], line};
                  bit_cnt   <= bit_cnt + 4'd1;
                  stall_cnt <= '0;
               end else if (!samp_sat) begin
                  samp_cnt <= samp_cnt + 1'b1;
               end
            end
            DONE: if (id_ok) ID <= shreg;
            default: ;
         endcase
         // A set in DONE takes priority over a simultaneous acknowledge.
         if (state == DONE && id_ok) ID_vld <= 1'b1;
         else if (clr_ID_vld)        ID_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_barcode_rx.sv
// Scoreboard bench for barcode_rx: expected IDs and update cycles are queued per frame.
module tb_barcode_rx;

   localparam int L = 100;
`ifdef BC_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       BC = 1'b1;
   logic       clr_ID_vld = 1'b0;
   logic [7:0] ID;
   logic       ID_vld;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         clr_at = -1;
   logic [7:0] exp_id[$];
   int         exp_cyc[$];
   logic       vld_q = 1'b0;

   barcode_rx #(.CNT_W(22), .FRAME_BITS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .BC         (BC),
      .clr_ID_vld (clr_ID_vld),
      .ID         (ID),
      .ID_vld     (ID_vld)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clr_ID_vld = (cyc == clr_at);
   endtask

   task automatic hold(input logic v, input int n);
      BC = v;
      repeat (n) step();
   endtask

   task automatic pulse_clr();
      clr_at = cyc + 1;
      step();
      step();
      clr_at = -1;
   endtask

   // Start bit low L, high L; then per bit: '1' = 50 low/150 high, '0' = 150 low/50 high.
   task automatic send_frame(input logic [7:0] val, input int nbits, input bit clr_in_done);
      int   e;
      logic b;
      hold(1'b0, L);
      hold(1'b1, L);
      for (int i = 0; i < nbits; i++) begin
         b  = val[7-i];
         BC = 1'b0;
         if (i == 7) begin
            e = cyc + L + 4 + FILT;
            if (val[7:6] == 2'b00) begin
               exp_id.push_back(val);
               exp_cyc.push_back(e);
            end
            if (clr_in_done) clr_at = e - 1;
         end
         hold(1'b0, b ? 50 : 150);
         hold(1'b1, b ? 150 : 50);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_id.size() != 0 && n < 400) begin
         step();
         n++;
      end
      check("done_timeout", exp_id.size(), 0);
   endtask

   always @(negedge clk) begin
      if (ID_vld && !vld_q) begin
         if (exp_id.size() == 0) begin
            check("spurious_vld", ID_vld, 0);
         end else begin
            check("id", ID, exp_id.pop_front());
            check("latency", cyc, exp_cyc.pop_front());
         end
      end
      vld_q = ID_vld;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_id", ID, 8'h00);
      check("rst_vld", ID_vld, 0);
      rst_n = 1'b1;
      hold(1'b1, 20);

      send_frame(8'h35, 8, 1'b0);
      hold(1'b1, 50);
      wait_done();
      hold(1'b1, 20);
      check("t1_vld_hold", ID_vld, 1);
      check("t1_id_hold", ID, 8'h35);

      pulse_clr();
      check("t2_vld_clr", ID_vld, 0);
      check("t2_id_keep", ID, 8'h35);

      send_frame(8'hF5, 8, 1'b0);
      hold(1'b1, 300);
      check("t3_vld", ID_vld, 0);
      check("t3_id", ID, 8'h35);

      send_frame(8'h0A, 4, 1'b0);
      rst_n = 1'b0;
      step();
      check("t4_rst_vld", ID_vld, 0);
      check("t4_rst_id", ID, 8'h00);
      rst_n = 1'b1;
      hold(1'b1, 20);
      send_frame(8'h0A, 8, 1'b0);
      hold(1'b1, 50);
      wait_done();
      check("t4_vld", ID_vld, 1);
      check("t4_id", ID, 8'h0A);

      pulse_clr();
      check("t5_clr", ID_vld, 0);
      hold(1'b0, L);
      hold(1'b1, 500);
      check("t5_abort_vld", ID_vld, 0);
      check("t5_abort_id", ID, 8'h0A);
      send_frame(8'h12, 8, 1'b0);
      hold(1'b1, 50);
      wait_done();
      check("t5_id", ID, 8'h12);

      pulse_clr();
      send_frame(8'h21, 8, 1'b1);
      clr_at = -1;
      hold(1'b1, 50);
      wait_done();
      check("t6_vld", ID_vld, 1);
      check("t6_id", ID, 8'h21);

`ifdef BC_GLITCH_FILTER_EN
      pulse_clr();
      hold(1'b0, 1);
      hold(1'b1, 3);
      check("glitch_vld", ID_vld, 0);
      send_frame(8'h2C, 8, 1'b0);
      hold(1'b1, 50);
      wait_done();
      check("glitch_id", ID, 8'h2C);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
